// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO pointer controller feeding an external dual-port memory.
// Defining FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_ctrl #(
   parameter int DATA_DEPTH  = 64,
   parameter int ADDR_WIDTH  = $clog2(DATA_DEPTH),
   parameter int AFULL_LEVEL = DATA_DEPTH - 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   output logic                  write_en,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [ADDR_WIDTH-1:0] read_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
`ifdef FIFO_ERR_FLAGS_EN
   output logic                  overflow,
   output logic                  underflow,
`endif
   output logic [ADDR_WIDTH:0]   count
);

   localparam logic [ADDR_WIDTH:0] PTR_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0] AFULL_CNT = (ADDR_WIDTH+1)'(AFULL_LEVEL);

   logic [ADDR_WIDTH:0] wr_ptr_r;
   logic [ADDR_WIDTH:0] rd_ptr_r;
   logic [ADDR_WIDTH:0] count_s;
   logic                full_s;
   logic                empty_s;
   logic                push_ok_s;
   logic                pop_ok_s;

   // Status and accept decisions, all derived from the registered pointer pair
   always_comb begin
      count_s   = wr_ptr_r - rd_ptr_r;
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]);
      push_ok_s = push & ~full_s;
      pop_ok_s  = pop & ~empty_s;
   end

   assign write_en    = push_ok_s;
   assign write_addr  = wr_ptr_r[ADDR_WIDTH-1:0];
   assign read_addr   = rd_ptr_r[ADDR_WIDTH-1:0];
   assign full        = full_s;
   assign empty       = empty_s;
   assign almost_full = (count_s >= AFULL_CNT);
   assign count       = count_s;

   // Pointer advance; the extra MSB toggles on each wrap to tell full from empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_r;
   logic underflow_r;

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= overflow_r | (push & full_s);
         underflow_r <= underflow_r | (pop & empty_s);
      end
   end

   assign overflow  = overflow_r;
   assign underflow = underflow_r;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl with an attached 64x8 memory model.
module tb_fifo_ctrl;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          write_en;
   logic [AW-1:0] write_addr;
   logic [AW-1:0] read_addr;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
   logic          overflow;
   logic          underflow;
`endif

   logic [7:0] write_data = 8'h00;
   logic [7:0] read_data;
   logic [7:0] mem [0:DEPTH-1];

   fifo_ctrl #(.DATA_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
      .write_en(write_en), .write_addr(write_addr), .read_addr(read_addr),
      .full(full), .empty(empty), .almost_full(almost_full),
`ifdef FIFO_ERR_FLAGS_EN
      .overflow(overflow), .underflow(underflow),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (write_en) mem[write_addr] <= write_data;
   end
   assign read_data = mem[read_addr];

   typedef struct {
      string      tag;
      logic       we;
      int         cnt;
      logic       emp;
      logic       ful;
      logic       af;
      int         wa;
      int         ra;
      logic       chk_data;
      logic [7:0] data;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state
   int         m_cnt = 0;
   int         m_wa = 0;
   int         m_ra = 0;
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;
   logic [7:0] m_data[$];
   logic [7:0] data_ctr = 8'h00;

   task automatic check(input string tag, input string field, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s.%s: got %0d expected %0d", tag, field, act, exp);
      end
   endtask

   // Monitor: compares DUT outputs on the falling edge against the queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, "write_en", int'(write_en), int'(e.we));
         check(e.tag, "count", int'(count), e.cnt);
         check(e.tag, "empty", int'(empty), int'(e.emp));
         check(e.tag, "full", int'(full), int'(e.ful));
         check(e.tag, "almost_full", int'(almost_full), int'(e.af));
         check(e.tag, "write_addr", int'(write_addr), e.wa);
         check(e.tag, "read_addr", int'(read_addr), e.ra);
         if (e.chk_data) check(e.tag, "read_data", int'(read_data), int'(e.data));
`ifdef FIFO_ERR_FLAGS_EN
         check(e.tag, "overflow", int'(overflow), int'(e.ovf));
         check(e.tag, "underflow", int'(underflow), int'(e.unf));
`endif
      end
   end

   task automatic model_step(input logic p, input logic q);
      logic pok, qok;
      pok = p && (m_cnt < DEPTH);
      qok = q && (m_cnt > 0);
      if (p && m_cnt == DEPTH) m_ovf = 1'b1;
      if (q && m_cnt == 0) m_unf = 1'b1;
      if (qok) begin
         void'(m_data.pop_front());
         m_ra = (m_ra + 1) % DEPTH;
         m_cnt--;
      end
      if (pok) begin
         m_data.push_back(write_data);
         m_wa = (m_wa + 1) % DEPTH;
         m_cnt++;
         data_ctr = data_ctr + 8'h01;
      end
   endtask

   // One traffic cycle: called just after a rising edge, expectation from the model
   task automatic cycle(input string tag, input logic p, input logic q);
      exp_t e;
      push = p;
      pop = q;
      write_data = data_ctr;
      e.tag = tag;
      e.we = p && (m_cnt < DEPTH);
      e.cnt = m_cnt;
      e.emp = (m_cnt == 0);
      e.ful = (m_cnt == DEPTH);
      e.af = (m_cnt >= DEPTH - 4);
      e.wa = m_wa;
      e.ra = m_ra;
      e.chk_data = (m_cnt != 0);
      e.data = (m_cnt != 0) ? m_data[0] : 8'h00;
      e.ovf = m_ovf;
      e.unf = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      model_step(p, q);
      #1;
   endtask

   // Idle cycle checked against hand-computed constants
   task automatic idle_expect(input string tag, input int cnt, input logic emp, input logic ful,
                              input logic af, input int wa, input int ra);
      exp_t e;
      push = 1'b0;
      pop = 1'b0;
      e.tag = tag;
      e.we = 1'b0;
      e.cnt = cnt;
      e.emp = emp;
      e.ful = ful;
      e.af = af;
      e.wa = wa;
      e.ra = ra;
      e.chk_data = 1'b0;
      e.data = 8'h00;
      e.ovf = m_ovf;
      e.unf = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_wa = 0;
      m_ra = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_data.delete();
      data_ctr = 8'h00;
   endtask

   initial begin
      exp_t e;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle_expect("reset", 0, 1'b1, 1'b0, 1'b0, 0, 0);

      // Asynchronous reset mid-traffic at count 5
      for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0);
      push = 1'b0;
      pop = 1'b0;
      #1;
      rst = 1'b1;
      e = '{tag: "async_rst", we: 1'b0, cnt: 0, emp: 1'b1, ful: 1'b0, af: 1'b0,
            wa: 0, ra: 0, chk_data: 1'b0, data: 8'h00, ovf: 1'b0, unf: 1'b0};
      exp_q.push_back(e);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Fill with 0x00..0x3F
      for (int i = 0; i < 59; i++) cycle("fill", 1'b1, 1'b0);
      idle_expect("fill59", 59, 1'b0, 1'b0, 1'b0, 59, 0);
      cycle("fill", 1'b1, 1'b0);
      idle_expect("fill60", 60, 1'b0, 1'b0, 1'b1, 60, 0);
      for (int i = 0; i < 4; i++) cycle("fill", 1'b1, 1'b0);
      idle_expect("fill64", 64, 1'b0, 1'b1, 1'b1, 0, 0);
      cycle("push_full", 1'b1, 1'b0);
      idle_expect("after_ovf", 64, 1'b0, 1'b1, 1'b1, 0, 0);

      // Drain, checking read_data order 0x00..0x3F
      for (int i = 0; i < 64; i++) cycle("drain", 1'b0, 1'b1);
      idle_expect("drained", 0, 1'b1, 1'b0, 1'b0, 0, 0);
      cycle("pop_empty", 1'b0, 1'b1);
      idle_expect("after_unf", 0, 1'b1, 1'b0, 1'b0, 0, 0);

      // Push+pop at empty, at 10, at full
      cycle("pp_empty", 1'b1, 1'b1);
      idle_expect("pp_empty_res", 1, 1'b0, 1'b0, 1'b0, 1, 0);
      for (int i = 0; i < 9; i++) cycle("to10", 1'b1, 1'b0);
      cycle("pp_10", 1'b1, 1'b1);
      idle_expect("pp_10_res", 10, 1'b0, 1'b0, 1'b0, 11, 1);
      for (int i = 0; i < 54; i++) cycle("to64", 1'b1, 1'b0);
      idle_expect("full_again", 64, 1'b0, 1'b1, 1'b1, 1, 1);
      cycle("pp_full", 1'b1, 1'b1);
      idle_expect("pp_full_res", 63, 1'b0, 1'b0, 1'b1, 1, 2);

      // Wrap-around at count 3
      for (int i = 0; i < 60; i++) cycle("to3", 1'b0, 1'b1);
      for (int i = 0; i < 100; i++) cycle("wrap", 1'b1, 1'b1);
      idle_expect("wrap_res", 3, 1'b0, 1'b0, 1'b0, 37, 34);

      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
